// File: rtl/ham_info_if.sv
// ============================================================================
// Module      : ham_info_if
// Description : Valid/ready handshake carrying 12-bit Hamming info words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ham_info_if;
  logic        info_valid;
  logic        info_ready;
  logic [11:0] info_bits;

  modport master (
    output info_valid,
    output info_bits,
    input  info_ready
  );

  modport slave (
    input  info_valid,
    input  info_bits,
    output info_ready
  );
endinterface

`default_nettype wire

// File: rtl/ham_info_src.sv
// ============================================================================
// Module      : ham_info_src
// Description : Pseudo-random 12-bit info-word source (x^12+x^6+x^4+x+1 LFSR)
//               that sends NUM_WORDS words per run over a valid/ready link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ham_info_src #(
  parameter logic [11:0] SEED      = 12'hACE,
  parameter int          NUM_WORDS = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic        stop,
  input  wire logic        seed_load,
  input  wire logic [11:0] seed_in,
  ham_info_if.master       info,
  output      logic [15:0] word_cnt,
  output      logic        busy,
  output      logic        done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // NUM_WORDS of zero means a continuous run; the last-count compare is then unused.
  localparam bit          C_COUNTED  = (NUM_WORDS != 0);
  localparam logic [15:0] C_LAST_CNT = 16'(NUM_WORDS - 1);

  logic [1:0]  state_q,    state_d;
  logic [11:0] lfsr_q,     lfsr_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic        transfer;
  logic        last_word;
  logic        fb;
  logic [11:0] lfsr_step;
  logic [11:0] seed_val;

  assign transfer  = (state_q == ST_RUN) && info.info_ready;
  assign last_word = C_COUNTED && (word_cnt_q == C_LAST_CNT);
  assign fb        = lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];
  assign lfsr_step = {lfsr_q[10:0], fb};
  assign seed_val  = (seed_in == 12'd0) ? SEED : seed_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // stop outranks everything; a transfer on the same edge still completes below.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (transfer && last_word) state_d = ST_DONE;
        ST_DONE: if (start) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (transfer) begin
      lfsr_d = lfsr_step;
    end else if ((state_q == ST_IDLE) && seed_load) begin
      lfsr_d = seed_val;
    end
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (transfer) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end else if ((state_q != ST_RUN) && start && !stop) begin
      word_cnt_d = 16'd0;
    end
  end

  always_comb begin
    info.info_valid = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state_q)
      ST_RUN: begin
        info.info_valid = 1'b1;
        busy            = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign info.info_bits = lfsr_q;
  assign word_cnt       = word_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ham_info_src.sv
// ============================================================================
// Module      : tb_ham_info_src
// Description : Directed self-checking bench for ham_info_src.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ham_info_src;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        seed_load;
  logic [11:0] seed_in;
  logic [15:0] word_cnt;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [11:0] seq [0:40];

  ham_info_if info ();

  ham_info_src #(
    .SEED      (12'hACE),
    .NUM_WORDS (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .info      (info.master),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and confirm outputs fall without waiting for a clock.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_valid"}, 32'(info.info_valid), 32'h0);
    check({tag, "_rst_busy"},  32'(busy),            32'h0);
    check({tag, "_rst_done"},  32'(done),            32'h0);
    check({tag, "_rst_cnt"},   32'(word_cnt),        32'h0);
    check({tag, "_rst_bits"},  32'(info.info_bits),  32'hACE);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [11:0] l;
    l = 12'hACE;
    for (int i = 0; i <= 40; i++) begin
      seq[i] = l;
      l = {l[10:0], l[11] ^ l[5] ^ l[3] ^ l[0]};
    end

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; seed_load = 1'b0;
    seed_in = 12'h000; info.info_ready = 1'b0;
    #12;
    check("reset_valid", 32'(info.info_valid), 32'h0);
    check("reset_bits",  32'(info.info_bits),  32'hACE);
    check("reset_cnt",   32'(word_cnt),        32'h0);
    check("reset_busy",  32'(busy),            32'h0);
    check("reset_done",  32'(done),            32'h0);
    rst_n = 1'b1;
    step();

    // Full run of 16 words with ready held high.
    start = 1'b1; info.info_ready = 1'b1;
    step();
    start = 1'b0;
    check("run_valid0", 32'(info.info_valid), 32'h1);
    check("run_busy0",  32'(busy),            32'h1);
    check("run_bits0",  32'(info.info_bits),  32'hACE);
    check("run_cnt0",   32'(word_cnt),        32'h0);
    step();
    check("run_bits1",  32'(info.info_bits),  32'h59C);
    check("run_cnt1",   32'(word_cnt),        32'h1);
    step();
    check("run_bits2",  32'(info.info_bits),  32'hB39);
    check("run_cnt2",   32'(word_cnt),        32'h2);
    for (int k = 3; k < 16; k++) begin
      step();
      check("run_bits_k", 32'(info.info_bits), 32'(seq[k]));
      check("run_cnt_k",  32'(word_cnt),        32'(k));
      check("run_done_k", 32'(done),            32'h0);
    end
    step();
    check("done_flag",  32'(done),            32'h1);
    check("done_cnt",   32'(word_cnt),        32'd16);
    check("done_valid", 32'(info.info_valid), 32'h0);
    check("done_busy",  32'(busy),            32'h0);
    step();
    check("done_hold_bits", 32'(info.info_bits), 32'(seq[16]));
    check("done_hold_cnt",  32'(word_cnt),       32'd16);

    // Restart from DONE continues the sequence without reseeding.
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_cnt",  32'(word_cnt),       32'h0);
    check("restart_bits", 32'(info.info_bits), 32'(seq[16]));
    step();
    check("restart_bits1", 32'(info.info_bits), 32'(seq[17]));
    check("restart_cnt1",  32'(word_cnt),       32'h1);
    pulse_reset("mid_run");

    // Stall: ready pattern 1,0,0,1 holds 0x59C without skipping.
    start = 1'b1; info.info_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    check("stall_bits_a", 32'(info.info_bits), 32'h59C);
    info.info_ready = 1'b0;
    step();
    check("stall_bits_b", 32'(info.info_bits), 32'h59C);
    step();
    check("stall_bits_c", 32'(info.info_bits), 32'h59C);
    check("stall_cnt",    32'(word_cnt),       32'h1);
    info.info_ready = 1'b1;
    step();
    check("stall_bits_d", 32'(info.info_bits), 32'hB39);
    check("stall_cnt_d",  32'(word_cnt),       32'h2);
    pulse_reset("stall");

    // Zero seed substitutes SEED; 0x001 seed with simultaneous start.
    info.info_ready = 1'b1;
    seed_in = 12'h000; seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check("seed0_bits",  32'(info.info_bits),  32'hACE);
    check("seed0_valid", 32'(info.info_valid), 32'h0);
    seed_in = 12'h001; seed_load = 1'b1; start = 1'b1;
    step();
    seed_load = 1'b0; start = 1'b0;
    check("seed1_bits0", 32'(info.info_bits),  32'h001);
    check("seed1_valid", 32'(info.info_valid), 32'h1);
    seed_in = 12'h555; seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check("seed1_bits1", 32'(info.info_bits), 32'h003);
    pulse_reset("seed");

    // stop coinciding with the sixth transfer.
    start = 1'b1; info.info_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("pre_stop_cnt", 32'(word_cnt), 32'd5);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    check("stop_valid", 32'(info.info_valid), 32'h0);
    check("stop_busy",  32'(busy),            32'h0);
    check("stop_cnt",   32'(word_cnt),        32'd6);
    check("stop_bits",  32'(info.info_bits),  32'(seq[6]));
    step();
    check("idle_hold_cnt", 32'(word_cnt), 32'd6);
    check("idle_valid",    32'(info.info_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
